// File: rtl/uart_mon_pkg.sv
// Shared types, default constants and helpers for the UART test monitor.
package uart_mon_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   localparam int unsigned CLK_DIV    = 108;
   localparam int unsigned OVERSAMPLE = 4;
   localparam logic [7:0]  HALT_CHAR  = 8'hFF;

   // Never returns less than 1 so counters and pointers keep a real width.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word-fall-through receive FIFO with a registered head word.
module uart_mon_fifo
   import uart_mon_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q, count;
   logic [WIDTH-1:0] rdata_q;
   logic [AW-1:0]    rnext;
   logic             pop_eff, push_eff;

   assign count    = wptr_q - rptr_q;
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);
   assign rnext    = rptr_q[AW-1:0] + AW'(1);
   assign rdata    = rdata_q;

   // NOTE: storage has no reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   // NOTE: sequential state uses <= so every flop sees the pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (push_eff) wptr_q <= wptr_q + 1'b1;
         if (pop_eff)  rptr_q <= rptr_q + 1'b1;
         // The head register follows the entry that will be at the head after this edge.
         if (push_eff && (empty || (pop_eff && count == (AW+1)'(1))))
            rdata_q <= wdata;
         else if (pop_eff && count > (AW+1)'(1))
            rdata_q <= mem_q[rnext];
      end
   end

endmodule

// File: rtl/uart_test_monitor.sv
// Oversampling UART receiver with receive FIFO, halt-character detector and watchdog.
// Define UART_MON_PARITY_EN to require an even-parity bit between data and stop.
module uart_test_monitor #(
   parameter int unsigned CLK_DIV        = uart_mon_pkg::CLK_DIV,
   parameter int unsigned OVERSAMPLE     = uart_mon_pkg::OVERSAMPLE,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned HALT_CHAR      = uart_mon_pkg::HALT_CHAR,
   parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 halt,
   output logic                 timeout,
   output logic                 frame_err,
   output logic                 overflow,
   output logic [15:0]          byte_cnt
);

   import uart_mon_pkg::*;

   localparam int unsigned CW = clog2(CLK_DIV);
   localparam int unsigned TW = clog2(OVERSAMPLE);
   localparam int unsigned BW = clog2(DATA_BITS);

   localparam logic [CW-1:0]        DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [TW-1:0]        TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0]        TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0]        BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [DATA_BITS-1:0] HALT_V    = DATA_BITS'(HALT_CHAR);

   logic                 rx_meta_q, rx_s_q;
   logic [CW-1:0]        div_q;
   logic                 tick;
   state_e               state_q;
   logic [TW-1:0]        tcnt_q;
   logic [BW-1:0]        bcnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 halt_q, timeout_q, frame_err_q, overflow_q;
   logic [15:0]          byte_cnt_q;
   logic [31:0]          wd_q;
`ifdef UART_MON_PARITY_EN
   logic                 par_err_q;
`endif

   logic stop_sample, frame_ok, is_halt, push, halt_set, wd_expire;
   logic fifo_empty, fifo_full;

   assign tick        = (div_q == DIV_LAST);
   assign stop_sample = tick && (state_q == STOP) && (tcnt_q == TICK_LAST);
`ifdef UART_MON_PARITY_EN
   assign frame_ok    = stop_sample && rx_s_q && !par_err_q;
`else
   assign frame_ok    = stop_sample && rx_s_q;
`endif
   assign is_halt     = (shift_q == HALT_V);
   assign push        = frame_ok && !is_halt;
   assign halt_set    = frame_ok && is_halt;
   assign wd_expire   = (TIMEOUT_CYCLES != 0) && (wd_q + 32'd1 == TIMEOUT_CYCLES);

   // rx is asynchronous to clk; two flops before anything looks at it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         div_q     <= '0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         div_q     <= tick ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
         halt_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         byte_cnt_q  <= '0;
`ifdef UART_MON_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         if (frame_ok && byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
         if (halt_set) halt_q <= 1'b1;
         if (push && fifo_full && !rd_en) overflow_q <= 1'b1;
         if (tick) begin
            unique case (state_q)
               IDLE: begin
                  if (!rx_s_q) begin
                     state_q <= START;
                     tcnt_q  <= '0;
                  end
               end
               START: begin
                  if (tcnt_q == TICK_MID) begin
                     tcnt_q <= '0;
                     bcnt_q <= '0;
                     state_q <= rx_s_q ? IDLE : DATA;
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tcnt_q == TICK_LAST) begin
                     tcnt_q          <= '0;
                     shift_q[bcnt_q] <= rx_s_q;
                     if (bcnt_q == BIT_LAST) begin
`ifdef UART_MON_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
               PARITY: begin
`ifdef UART_MON_PARITY_EN
                  if (tcnt_q == TICK_LAST) begin
                     tcnt_q    <= '0;
                     par_err_q <= (^shift_q) ^ rx_s_q;
                     state_q   <= STOP;
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
`else
                  state_q <= IDLE;
`endif
               end
               STOP: begin
                  if (tcnt_q == TICK_LAST) begin
                     tcnt_q  <= '0;
                     state_q <= IDLE;
`ifdef UART_MON_PARITY_EN
                     if (!rx_s_q || par_err_q) frame_err_q <= 1'b1;
`else
                     if (!rx_s_q) frame_err_q <= 1'b1;
`endif
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Watchdog freezes once halt or timeout is set; halt wins a same-cycle tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (!halt_q && !timeout_q && TIMEOUT_CYCLES != 0) begin
         wd_q <= wd_q + 32'd1;
         if (wd_expire && !halt_set) timeout_q <= 1'b1;
      end
   end

   uart_mon_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .wdata  (shift_q),
      .pop    (rd_en),
      .rdata  (rd_data),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   assign rd_valid  = !fifo_empty;
   assign halt      = halt_q;
   assign timeout   = timeout_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign byte_cnt  = byte_cnt_q;

endmodule
